// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES-128 constants, tables and helper functions
//
// Purpose: S-box table, round-constant array, xtime / MixColumns column
//          helpers, AES-128 size constants and the encrypt FSM state enum.
// Ports:   none (package).
package aes_pkg;

    localparam int AES_N  = 128;
    localparam int AES_NR = 10;
    localparam int AES_NK = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } aes_state_e;

    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Indexed directly by the 4-bit round counter; entries outside 1..10 are never used.
    localparam logic [7:0] RCON [0:15] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
        8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
    };

    // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // One MixColumns column; byte 0 of the column sits in [31:24].
    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// rtl/aes_sbox.sv - combinational AES forward S-box byte lookup
//
// Purpose: single-byte SubBytes substitution.
// Ports:   in_byte  - byte to substitute
//          out_byte - substituted byte
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    assign out_byte = SBOX[in_byte];

endmodule

// File: rtl/aes_encrypt_iter.sv
// rtl/aes_encrypt_iter.sv - iterative AES-128 encryption core, one round per clock
//
// Purpose: accepts plaintext+key, runs 10 rounds with on-the-fly key
//          expansion, presents ciphertext until the downstream accepts it.
// Ports:   clk, rst_n                     - clock, async active-low reset
//          in_valid/in_ready/in_data/in_key - plaintext and key channel
//          out_valid/out_ready/out_data   - ciphertext channel
// Build option: AES_ENC_ZEROIZE_EN clears state, round key and out_data on
//          the output handshake.
module aes_encrypt_iter
    import aes_pkg::*;
#(
    parameter int N  = AES_N,
    parameter int Nr = AES_NR,
    parameter int Nk = AES_NK
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [127:0]   in_data,
    input  logic [N-1:0]   in_key,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [127:0]   out_data
);

    if (N != 128) begin : g_bad_n
        $error("aes_encrypt_iter: N must be 128");
    end
    if (Nr != 10) begin : g_bad_nr
        $error("aes_encrypt_iter: Nr must be 10");
    end
    if (Nk != 4) begin : g_bad_nk
        $error("aes_encrypt_iter: Nk must be 4");
    end

    localparam logic [3:0] LAST_RND = 4'(Nr);

    aes_state_e   fsm_q;
    logic [127:0] state_q;
    logic [127:0] rkey_q;
    logic [127:0] out_data_q;
    logic [3:0]   rnd_q;
    logic         in_ready_q;
    logic         out_valid_q;

    logic [31:0]  ks_sub;
    logic [31:0]  key_temp;
    logic [31:0]  nw0, nw1, nw2, nw3;
    logic [127:0] rkey_d;
    logic [127:0] sub_bytes;
    logic [127:0] shift_rows;
    logic [127:0] mix_cols;
    logic [127:0] state_d;

    // ---------------- key schedule ----------------
    // Substitute the last word first; rotating afterwards is equivalent
    // to SubWord(RotWord(w3)) because both act bytewise.
    for (genvar i = 0; i < 4; i++) begin : g_ks_sbox
        aes_sbox u_ks_sbox (
            .in_byte  (rkey_q[8*i+7 -: 8]),
            .out_byte (ks_sub[8*i+7 -: 8])
        );
    end

    assign key_temp = {ks_sub[23:0], ks_sub[31:24]} ^ {RCON[rnd_q], 24'h000000};
    assign nw0      = rkey_q[127:96] ^ key_temp;
    assign nw1      = rkey_q[95:64]  ^ nw0;
    assign nw2      = rkey_q[63:32]  ^ nw1;
    assign nw3      = rkey_q[31:0]   ^ nw2;
    assign rkey_d   = {nw0, nw1, nw2, nw3};

    // ---------------- round datapath ----------------
    for (genvar i = 0; i < 16; i++) begin : g_st_sbox
        aes_sbox u_st_sbox (
            .in_byte  (state_q[8*i+7 -: 8]),
            .out_byte (sub_bytes[8*i+7 -: 8])
        );
    end

    // Byte (row r, column c) lives at index 4c+r counted from the MSB.
    // ShiftRows moves row r left by r columns.
    always_comb begin
        shift_rows = '0;
        mix_cols   = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                shift_rows[127-8*(4*c+r) -: 8] = sub_bytes[127-8*(4*((c+r)%4)+r) -: 8];
            end
        end
        for (int c = 0; c < 4; c++) begin
            mix_cols[127-32*c -: 32] = mix_column(shift_rows[127-32*c -: 32]);
        end
    end

    assign state_d = ((rnd_q == LAST_RND) ? shift_rows : mix_cols) ^ rkey_d;

    // ---------------- control FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q       <= IDLE;
            state_q     <= '0;
            rkey_q      <= '0;
            out_data_q  <= '0;
            rnd_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (fsm_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        state_q    <= in_data ^ in_key;
                        rkey_q     <= in_key;
                        rnd_q      <= 4'd1;
                        in_ready_q <= 1'b0;
                        fsm_q      <= ROUND;
                    end
                end
                ROUND: begin
                    state_q <= state_d;
                    rkey_q  <= rkey_d;
                    if (rnd_q == LAST_RND) begin
                        // Counter parks at Nr rather than wrapping.
                        out_data_q  <= state_d;
                        out_valid_q <= 1'b1;
                        fsm_q       <= DONE;
                    end else begin
                        rnd_q <= rnd_q + 4'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        fsm_q       <= IDLE;
`ifdef AES_ENC_ZEROIZE_EN
                        state_q     <= '0;
                        rkey_q      <= '0;
                        out_data_q  <= '0;
`endif
                    end
                end
                default: begin
                    fsm_q       <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule
